// File: rtl/axi_wr_arbiter_2x1_pkg.sv
// Shared types for the 2x1 AXI arbiters.
// Read and write path arbiters both use these.
package axi_wr_arbiter_2x1_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AW   = 2'd1,
    W    = 2'd2,
    B    = 2'd3
  } wr_arb_state_t;

  localparam logic SEL_M0 = 1'b0;
  localparam logic SEL_M1 = 1'b1;

endpackage

// File: rtl/axi_wr_arbiter_2x1_rr_arb_2.sv
// Two-request winner select, round-robin or fixed priority.
// Output is only meaningful while a request is present.
module rr_arb_2
  import axi_wr_arbiter_2x1_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last_grant,
  output logic o_grant
);

  // Pick the winner from the current requests and the previous grant
  always_comb begin
    o_grant = SEL_M0;
    if (FIXED_PRIO != 0) begin
      o_grant = i_req0 ? SEL_M0 : SEL_M1;
    end else if (i_req0 && i_req1) begin
      o_grant = ~i_last_grant;
    end else begin
      o_grant = i_req1 ? SEL_M1 : SEL_M0;
    end
  end

endmodule

// File: rtl/axi_wr_arbiter_2x1.sv
// Two-master AXI4 write-path arbiter steering the AW/W/B muxes.
// Grant is held from AW through the W burst to the B response.
module axi_wr_arbiter_2x1 #(
  parameter int FIXED_PRIO = 0,
  parameter int LEN_W      = 8
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic             M0_AWVALID,
  input  logic             M1_AWVALID,
  output logic             M0_AWREADY,
  output logic             M1_AWREADY,
  input  logic             M0_WVALID,
  input  logic             M1_WVALID,
  input  logic             M0_WLAST,
  input  logic             M1_WLAST,
  output logic             M0_WREADY,
  output logic             M1_WREADY,
  output logic             M0_BVALID,
  output logic             M1_BVALID,
  input  logic             M0_BREADY,
  input  logic             M1_BREADY,
  output logic             S_AWVALID,
  input  logic             S_AWREADY,
  input  logic [LEN_W-1:0] S_AWLEN,
  output logic             S_WVALID,
  output logic             S_WLAST,
  input  logic             S_WREADY,
  input  logic             S_BVALID,
  output logic             S_BREADY,
  output logic             sel,
  output logic             len_err
);

  import axi_wr_arbiter_2x1_pkg::*;

  wr_arb_state_t    r_state;
  logic             r_sel;
  logic             r_last_grant;
  logic [LEN_W-1:0] r_beat;
  logic [LEN_W-1:0] r_len_q;
  logic             r_len_err;

  logic w_grant;
  logic w_any_req;
  logic w_in_aw;
  logic w_in_w;
  logic w_in_b;
  logic w_m0;
  logic w_m1;
  logic w_m_awvalid;
  logic w_m_wvalid;
  logic w_m_wlast;
  logic w_m_bready;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_b_hs;

  rr_arb_2 #(
    .FIXED_PRIO (FIXED_PRIO)
  ) u_rr_arb (
    .i_req0       (M0_AWVALID),
    .i_req1       (M1_AWVALID),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant)
  );

  assign w_any_req = M0_AWVALID | M1_AWVALID;

  assign w_in_aw = (r_state == AW);
  assign w_in_w  = (r_state == W);
  assign w_in_b  = (r_state == B);

  assign w_m0 = (r_sel == SEL_M0);
  assign w_m1 = (r_sel == SEL_M1);

  assign w_m_awvalid = w_m1 ? M1_AWVALID : M0_AWVALID;
  assign w_m_wvalid  = w_m1 ? M1_WVALID  : M0_WVALID;
  assign w_m_wlast   = w_m1 ? M1_WLAST   : M0_WLAST;
  assign w_m_bready  = w_m1 ? M1_BREADY  : M0_BREADY;

  assign S_AWVALID = w_in_aw & w_m_awvalid;
  assign S_WVALID  = w_in_w & w_m_wvalid;
  assign S_WLAST   = w_in_w & w_m_wlast;
  assign S_BREADY  = w_in_b & w_m_bready;

  assign M0_AWREADY = w_in_aw & w_m0 & S_AWREADY;
  assign M1_AWREADY = w_in_aw & w_m1 & S_AWREADY;
  assign M0_WREADY  = w_in_w & w_m0 & S_WREADY;
  assign M1_WREADY  = w_in_w & w_m1 & S_WREADY;
  assign M0_BVALID  = w_in_b & w_m0 & S_BVALID;
  assign M1_BVALID  = w_in_b & w_m1 & S_BVALID;

  assign w_aw_hs = S_AWVALID & S_AWREADY;
  assign w_w_hs  = S_WVALID & S_WREADY;
  assign w_b_hs  = S_BVALID & S_BREADY;

  assign sel     = r_sel;
  assign len_err = r_len_err;

  // Transaction FSM with registered grant, beat count and error pulse
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state      <= IDLE;
      r_sel        <= SEL_M0;
      r_last_grant <= SEL_M1;
      r_beat       <= '0;
      r_len_q      <= '0;
      r_len_err    <= 1'b0;
    end else begin
      r_len_err <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_sel   <= w_grant;
            r_state <= AW;
          end
        end
        AW: begin
          if (w_aw_hs) begin
            r_len_q <= S_AWLEN;
            r_beat  <= '0;
            r_state <= W;
          end
        end
        W: begin
          if (w_w_hs) begin
            r_beat    <= r_beat + 1'b1;
            r_len_err <= w_m_wlast ^ (r_beat == r_len_q);
            if (w_m_wlast) begin
              r_state <= B;
            end
          end
        end
        B: begin
          if (w_b_hs) begin
            r_last_grant <= r_sel;
            r_state      <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_wr_arbiter_2x1.sv
// Scoreboard bench for axi_wr_arbiter_2x1.
// Round-robin DUT is driven per transaction; a fixed-priority copy joins the contention run.
module tb_axi_wr_arbiter_2x1;

  localparam int LW = 8;

  logic ACLK = 1'b0;
  logic ARESET = 1'b1;

  logic M0_AWVALID = 0, M1_AWVALID = 0;
  logic M0_WVALID = 0, M1_WVALID = 0;
  logic M0_WLAST = 0, M1_WLAST = 0;
  logic M0_BREADY = 0, M1_BREADY = 0;
  logic S_AWREADY = 0, S_WREADY = 0, S_BVALID = 0;
  logic [LW-1:0] S_AWLEN = '0;

  logic M0_AWREADY, M1_AWREADY, M0_WREADY, M1_WREADY;
  logic M0_BVALID, M1_BVALID;
  logic S_AWVALID, S_WVALID, S_WLAST, S_BREADY, sel, len_err;

  logic f_M0_AWREADY, f_M1_AWREADY, f_M0_WREADY, f_M1_WREADY;
  logic f_M0_BVALID, f_M1_BVALID;
  logic f_S_AWVALID, f_S_WVALID, f_S_WLAST, f_S_BREADY, f_sel, f_len_err;

  always #5 ACLK = ~ACLK;

  axi_wr_arbiter_2x1 #(.FIXED_PRIO(0), .LEN_W(LW)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .M0_AWVALID(M0_AWVALID), .M1_AWVALID(M1_AWVALID),
    .M0_AWREADY(M0_AWREADY), .M1_AWREADY(M1_AWREADY),
    .M0_WVALID(M0_WVALID), .M1_WVALID(M1_WVALID),
    .M0_WLAST(M0_WLAST), .M1_WLAST(M1_WLAST),
    .M0_WREADY(M0_WREADY), .M1_WREADY(M1_WREADY),
    .M0_BVALID(M0_BVALID), .M1_BVALID(M1_BVALID),
    .M0_BREADY(M0_BREADY), .M1_BREADY(M1_BREADY),
    .S_AWVALID(S_AWVALID), .S_AWREADY(S_AWREADY), .S_AWLEN(S_AWLEN),
    .S_WVALID(S_WVALID), .S_WLAST(S_WLAST), .S_WREADY(S_WREADY),
    .S_BVALID(S_BVALID), .S_BREADY(S_BREADY),
    .sel(sel), .len_err(len_err)
  );

  axi_wr_arbiter_2x1 #(.FIXED_PRIO(1), .LEN_W(LW)) dut_fp (
    .ACLK(ACLK), .ARESET(ARESET),
    .M0_AWVALID(M0_AWVALID), .M1_AWVALID(M1_AWVALID),
    .M0_AWREADY(f_M0_AWREADY), .M1_AWREADY(f_M1_AWREADY),
    .M0_WVALID(M0_WVALID), .M1_WVALID(M1_WVALID),
    .M0_WLAST(M0_WLAST), .M1_WLAST(M1_WLAST),
    .M0_WREADY(f_M0_WREADY), .M1_WREADY(f_M1_WREADY),
    .M0_BVALID(f_M0_BVALID), .M1_BVALID(f_M1_BVALID),
    .M0_BREADY(M0_BREADY), .M1_BREADY(M1_BREADY),
    .S_AWVALID(f_S_AWVALID), .S_AWREADY(S_AWREADY), .S_AWLEN(S_AWLEN),
    .S_WVALID(f_S_WVALID), .S_WLAST(f_S_WLAST), .S_WREADY(S_WREADY),
    .S_BVALID(S_BVALID), .S_BREADY(f_S_BREADY),
    .sel(f_sel), .len_err(f_len_err)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  typedef struct {
    logic sel;
    int   errs;
    int   beats;
  } exp_t;

  exp_t sb[$];
  logic q_rr[$];
  logic q_fp[$];

  int mon_beats = 0;
  int mon_errs = 0;
  int err_late = 0;
  int fp_m1 = 0;
  bit prev_whs = 0;
  bit fp_on = 0;

  always @(negedge ACLK) begin
    if (ARESET) begin
      prev_whs = 0;
    end else begin
      if (len_err && !prev_whs) err_late++;
      prev_whs = S_WVALID && S_WREADY;
      if (S_WVALID && S_WREADY) mon_beats++;
      if (len_err) mon_errs++;
      if (q_rr.size() > 0 && S_AWVALID && S_AWREADY)
        chk("rr_grant", int'(sel), int'(q_rr.pop_front()));
      if (q_fp.size() > 0 && f_S_AWVALID && S_AWREADY)
        chk("fp_grant", int'(f_sel), int'(q_fp.pop_front()));
      if (fp_on && f_M1_AWREADY) fp_m1++;
    end
  end

  function automatic int idle_bits();
    return int'({S_AWVALID, S_WVALID, S_WLAST, S_BREADY,
                 M0_AWREADY, M1_AWREADY, M0_WREADY, M1_WREADY,
                 M0_BVALID, M1_BVALID, len_err});
  endfunction

  function automatic int other_bits(input logic m);
    if (m) return int'(M0_AWREADY) + int'(M0_WREADY) + int'(M0_BVALID);
    return int'(M1_AWREADY) + int'(M1_WREADY) + int'(M1_BVALID);
  endfunction

  task automatic drv(input logic m, input logic aw, input logic wv,
                     input logic wl, input logic br);
    if (m) begin
      M1_AWVALID = aw; M1_WVALID = wv; M1_WLAST = wl; M1_BREADY = br;
    end else begin
      M0_AWVALID = aw; M0_WVALID = wv; M0_WLAST = wl; M0_BREADY = br;
    end
  endtask

  task automatic drive_txn(input logic m, input int len, input int nb,
                           input int aw_dly, input bit tog, input int b_dly);
    exp_t e;
    int b0, e0, g, beat, sel_bad, oth, early;
    logic s0;
    bit hs;
    e.sel = m;
    e.beats = nb;
    e.errs = 0;
    for (int i = 0; i < nb; i++)
      if ((i == nb - 1) != (i == len)) e.errs++;
    sb.push_back(e);
    b0 = mon_beats;
    e0 = mon_errs;
    sel_bad = 0;
    oth = 0;
    early = 0;
    S_AWLEN = LW'(len);
    S_AWREADY = 0;
    S_WREADY = 1;
    drv(m, 1, 1, nb == 1, 0);
    @(posedge ACLK); #1;
    chk("aw_lat", int'(S_AWVALID), 1);
    s0 = sel;
    g = 0;
    hs = 0;
    while (!hs && g < 200) begin
      S_AWREADY = (g >= aw_dly);
      #1;
      hs = m ? M1_AWREADY : M0_AWREADY;
      if (m ? M1_WREADY : M0_WREADY) early++;
      oth += other_bits(m);
      @(posedge ACLK); #1;
      if (sel !== s0) sel_bad++;
      g++;
    end
    chk("aw_done", int'(hs), 1);
    S_AWREADY = 0;
    beat = 0;
    g = 0;
    while (beat < nb && g < 200) begin
      drv(m, 0, 1, beat == nb - 1, 0);
      S_WREADY = tog ? ((g % 2) == 1) : 1'b1;
      #1;
      hs = m ? M1_WREADY : M0_WREADY;
      oth += other_bits(m);
      @(posedge ACLK); #1;
      if (hs) beat++;
      if (sel !== s0) sel_bad++;
      g++;
    end
    chk("w_done", beat, nb);
    S_WREADY = 0;
    drv(m, 0, 0, 0, 1);
    g = 0;
    hs = 0;
    while (!hs && g < 200) begin
      S_BVALID = (g >= b_dly);
      #1;
      hs = m ? M1_BVALID : M0_BVALID;
      oth += other_bits(m);
      @(posedge ACLK); #1;
      if (sel !== s0) sel_bad++;
      g++;
    end
    chk("b_done", int'(hs), 1);
    S_BVALID = 0;
    #1;
    chk("idle_out", idle_bits(), 0);
    drv(m, 0, 0, 0, 0);
    e = sb.pop_front();
    chk("sel", int'(s0), int'(e.sel));
    chk("beats", mon_beats - b0, e.beats);
    chk("len_err", mon_errs - e0, e.errs);
    chk("sel_stable", sel_bad, 0);
    chk("other_quiet", oth, 0);
    chk("no_early_w", early, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge ACLK);
    #1;
    chk("rst_sel", int'(sel), 0);
    chk("rst_out", idle_bits(), 0);
    ARESET = 0;
    @(posedge ACLK); #1;
    chk("idle_hold", idle_bits(), 0);

    drive_txn(1'b0, 3, 4, 0, 1'b0, 0);
    drive_txn(1'b1, 1, 2, 0, 1'b0, 0);
    drive_txn(1'b0, 2, 2, 0, 1'b0, 0);
    drive_txn(1'b1, 3, 4, 5, 1'b1, 7);
    drive_txn(1'b0, 0, 2, 0, 1'b0, 0);
    chk("len_err_timing", err_late, 0);

    drv(1'b1, 1, 0, 0, 0);
    S_AWLEN = 8'd3;
    S_AWREADY = 1;
    @(posedge ACLK); #1;
    @(posedge ACLK); #1;
    S_AWREADY = 0;
    drv(1'b1, 0, 1, 0, 0);
    S_WREADY = 1;
    @(posedge ACLK); #1;
    chk("midw_sel", int'(sel), 1);
    chk("midw_wready", int'(M1_WREADY), 1);
    ARESET = 1;
    #1;
    chk("rstw_sel", int'(sel), 0);
    chk("rstw_out", idle_bits(), 0);
    drv(1'b1, 0, 0, 0, 0);
    S_WREADY = 0;
    @(posedge ACLK); #1;
    ARESET = 0;

    q_rr.push_back(1'b0);
    q_rr.push_back(1'b1);
    q_rr.push_back(1'b0);
    q_fp.push_back(1'b0);
    q_fp.push_back(1'b0);
    q_fp.push_back(1'b0);
    fp_on = 1;
    S_AWLEN = '0;
    S_AWREADY = 1;
    S_WREADY = 1;
    S_BVALID = 1;
    drv(1'b0, 1, 1, 1, 1);
    drv(1'b1, 1, 1, 1, 1);
    repeat (16) @(posedge ACLK);
    #1;
    M0_AWVALID = 0;
    M1_AWVALID = 0;
    fp_on = 0;
    repeat (6) @(posedge ACLK);
    #1;
    chk("rr_q_empty", q_rr.size(), 0);
    chk("fp_q_empty", q_fp.size(), 0);
    chk("fp_starve", fp_m1, 0);
    drv(1'b0, 0, 0, 0, 0);
    drv(1'b1, 0, 0, 0, 0);
    S_AWREADY = 0;
    S_WREADY = 0;
    S_BVALID = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
